ocx_tlx_param_fifo: RTL and testbench
=====================================

OCX_TLX_PARAM_FIFO -- requirements
Module: ocx_tlx_param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 514: entry width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: physical depth DEPTH = 2^ADDR_WIDTH entries.
REQ-003 SHALL have parameter MIN_DEPTH, default 4: effective depth when use_min_fifo_depth=1; legal range 1..DEPTH.
REQ-004 SHALL have parameter AFULL_MARGIN, default 2: almost-full distance from effective depth; legal range 0..MIN_DEPTH-1.
REQ-005 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port data_in, input, DATA_WIDTH: write data.
REQ-008 SHALL have port wr_enable, input, 1: push data_in this cycle.
REQ-009 SHALL have port rd_done, input, 1: consumer has taken data_out; pop head.
REQ-010 SHALL have port use_min_fifo_depth, input, 1: select effective depth EFF = MIN_DEPTH, else DEPTH.
REQ-011 SHALL have port data_out, output, DATA_WIDTH: registered head entry.
REQ-012 SHALL have port data_available, output, 1: data_out holds a valid head entry.
REQ-013 SHALL have port data_look_ahead, output, 1: a second entry exists behind the head.
REQ-014 SHALL have port occupancy, output, ADDR_WIDTH+1: stored entries, head included.
REQ-015 SHALL have port full, output, 1: occupancy >= EFF.
REQ-016 SHALL have port almost_full, output, 1: occupancy >= EFF - AFULL_MARGIN.
REQ-017 SHALL have port underflow_error, output, 1: sticky pop-while-empty flag.
REQ-018 SHALL have port overflow_error, output, 1: sticky push-while-full flag.

Function
REQ-019 Storage SHALL be an internal DEPTH x DATA_WIDTH register array with ADDR_WIDTH-bit write/read pointers wrapping modulo DEPTH.
REQ-020 Operation SHALL be first-word-fall-through: push into empty FIFO at edge N gives data_available=1 and data_out=that word after edge N.
REQ-021 Push SHALL be accepted when wr_enable=1 and (occupancy < EFF, or rd_done=1 with occupancy > 0 in the same cycle).
REQ-022 Pop SHALL be accepted when rd_done=1 and occupancy > 0; after the edge, data_out = next entry, or data_in if occupancy was 1 and a push is accepted in the same cycle.
REQ-023 Accepted push and pop in the same cycle SHALL leave occupancy unchanged and both pointers SHALL advance.
REQ-024 data_out SHALL hold its last value while data_available=0.
REQ-025 data_available SHALL equal (occupancy >= 1), data_look_ahead SHALL equal (occupancy >= 2), all flags registered and consistent with occupancy in the same cycle.
REQ-026 Rejected push (full, no simultaneous pop) SHALL drop data, leave storage unchanged and set overflow_error on the next edge.
REQ-027 rd_done with occupancy=0 SHALL be ignored and set underflow_error on the next edge; a same-cycle push into empty FIFO SHALL still be accepted.
REQ-028 Error flags SHALL remain set until reset_n asserts.
REQ-029 use_min_fifo_depth SHALL be sampled every cycle; if switched to 1 while occupancy > MIN_DEPTH, no entries are lost, full=1 until occupancy drops below MIN_DEPTH.
REQ-030 Occupancy SHALL never exceed DEPTH; EFF - AFULL_MARGIN SHALL be computed without underflow at ADDR_WIDTH+1 bits.

Reset
REQ-031 reset_n=0 SHALL asynchronously clear pointers, occupancy, data_available, data_look_ahead, full, almost_full, underflow_error, overflow_error and data_out to 0.
REQ-032 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-033 First push SHALL be accepted on the first rising edge after reset_n deasserts.

Verification (DATA_WIDTH=514, ADDR_WIDTH=4, MIN_DEPTH=4, AFULL_MARGIN=2)
REQ-034 Push 16 words 0..15, no pops -> occupancy=16, full=1, almost_full=1 from occupancy 14; 17th push -> overflow_error=1, then pops return 0..15 in order.
REQ-035 Push one word 0xA5 into empty FIFO -> next cycle data_available=1, data_look_ahead=0, data_out=0xA5; rd_done -> data_available=0, data_out stays 0xA5.
REQ-036 Continuous push+pop for 40 cycles starting at occupancy 1 -> occupancy stays 1, data order preserved across pointer wrap, no error flags.
REQ-037 use_min_fifo_depth=1, push 5 words -> full=1 at occupancy 4, 5th push sets overflow_error; with full=1 push+rd_done same cycle -> accepted, occupancy stays 4.
REQ-038 rd_done on empty FIFO -> underflow_error=1 next cycle and stays 1; reset_n=0 with occupancy 7 -> all outputs 0 immediately, occupancy=0 after release.

Source files
------------

// File: rtl/ocx_tlx_param_fifo.sv
// First-word-fall-through FIFO with a registered head word, a selectable
// effective depth, registered status flags and sticky error flags.
module ocx_tlx_param_fifo #(
  parameter int DATA_WIDTH   = 514,
  parameter int ADDR_WIDTH   = 4,
  parameter int MIN_DEPTH    = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_enable,
  input  logic                  rd_done,
  input  logic                  use_min_fifo_depth,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_available,
  output logic                  data_look_ahead,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full,
  output logic                  almost_full,
  output logic                  underflow_error,
  output logic                  overflow_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] MIN_C    = (ADDR_WIDTH+1)'(MIN_DEPTH);
  localparam logic [ADDR_WIDTH:0] MARGIN_C = (ADDR_WIDTH+1)'(AFULL_MARGIN);
  localparam logic [ADDR_WIDTH:0] ZERO_C   = '0;
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] TWO_C    = (ADDR_WIDTH+1)'(2);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_occ;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_avail;
  logic                  r_look_ahead;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_underflow;
  logic                  r_overflow;

  logic [ADDR_WIDTH:0]   w_eff;
  logic [ADDR_WIDTH:0]   w_afull_thr;
  logic                  w_pop;
  logic                  w_push;
  logic [ADDR_WIDTH:0]   w_occ_next;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_inc;

  // Effective depth and almost-full threshold (clamped so it cannot wrap).
  always_comb begin
    w_eff       = use_min_fifo_depth ? MIN_C : DEPTH_C;
    w_afull_thr = (w_eff > MARGIN_C) ? (w_eff - MARGIN_C) : ZERO_C;
  end

  // Accept decisions: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    w_pop        = rd_done && (r_occ != ZERO_C);
    w_push       = wr_enable && ((r_occ < w_eff) || w_pop);
    w_rd_ptr_inc = r_rd_ptr + ADDR_WIDTH'(1);
    w_wr_ptr_inc = r_wr_ptr + ADDR_WIDTH'(1);
    w_occ_next   = r_occ;
    if (w_push && !w_pop) begin
      w_occ_next = r_occ + ONE_C;
    end else if (w_pop && !w_push) begin
      w_occ_next = r_occ - ONE_C;
    end
  end

  // Storage write; contents are not reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_avail      <= 1'b0;
      r_look_ahead <= 1'b0;
      r_full       <= 1'b0;
      r_afull      <= 1'b0;
      r_underflow  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_occ        <= w_occ_next;
      r_avail      <= (w_occ_next >= ONE_C);
      r_look_ahead <= (w_occ_next >= TWO_C);
      r_full       <= (w_occ_next >= w_eff);
      r_afull      <= (w_occ_next >= w_afull_thr);
      if (rd_done && (r_occ == ZERO_C)) r_underflow <= 1'b1;
      if (wr_enable && !w_push)         r_overflow  <= 1'b1;
    end
  end

  // Head register: load data_in when it becomes the head, else the next entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
    end else if (w_push && ((r_occ == ZERO_C) || (w_pop && (r_occ == ONE_C)))) begin
      r_data_out <= data_in;
    end else if (w_pop && (r_occ >= TWO_C)) begin
      r_data_out <= r_mem[w_rd_ptr_inc];
    end
  end

  assign data_out        = r_data_out;
  assign data_available  = r_avail;
  assign data_look_ahead = r_look_ahead;
  assign occupancy       = r_occ;
  assign full            = r_full;
  assign almost_full     = r_afull;
  assign underflow_error = r_underflow;
  assign overflow_error  = r_overflow;

endmodule

// File: tb/tb_ocx_tlx_param_fifo.sv
// Table-driven bench for ocx_tlx_param_fifo with a data scoreboard queue.
module tb_ocx_tlx_param_fifo;
  localparam int DW = 514;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wr_enable = 1'b0;
  logic          rd_done = 1'b0;
  logic          use_min_fifo_depth = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_available;
  logic          data_look_ahead;
  logic [AW:0]   occupancy;
  logic          full;
  logic          almost_full;
  logic          underflow_error;
  logic          overflow_error;

  ocx_tlx_param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MIN_DEPTH(4), .AFULL_MARGIN(2)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .wr_enable(wr_enable),
    .rd_done(rd_done), .use_min_fifo_depth(use_min_fifo_depth), .data_out(data_out),
    .data_available(data_available), .data_look_ahead(data_look_ahead),
    .occupancy(occupancy), .full(full), .almost_full(almost_full),
    .underflow_error(underflow_error), .overflow_error(overflow_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          wr;
    bit          rd;
    bit          um;
    int unsigned d;
    int unsigned occ;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_out;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [DW-1:0] mk(input int unsigned d);
    logic [31:0] w;
    w = d;
    return {w[1:0], {16{w}}};
  endfunction

  task automatic add(input bit rst, input bit wr, input bit rd, input bit um,
                     input int unsigned d, input int unsigned occ, input bit ovf, input bit unf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.um = um;
    v.d = d; v.occ = occ; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_zero(input int idx);
    check("rst_occ", idx, DW'(occupancy), '0);
    check("rst_avail", idx, DW'(data_available), '0);
    check("rst_la", idx, DW'(data_look_ahead), '0);
    check("rst_full", idx, DW'(full), '0);
    check("rst_afull", idx, DW'(almost_full), '0);
    check("rst_ovf", idx, DW'(overflow_error), '0);
    check("rst_unf", idx, DW'(underflow_error), '0);
    check("rst_dout", idx, data_out, '0);
  endtask

  initial begin
    int unsigned eff;
    int          n;
    bit          pop_ok;
    bit          push_ok;

    // Clean start
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // Single word A5, then pop: head holds its value once empty
    add(0, 1, 0, 0, 32'hA5, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Streaming at occupancy 1 across pointer wrap
    add(0, 1, 0, 0, 100, 1, 0, 0);
    for (int i = 0; i < 40; i++) add(0, 1, 1, 0, 101 + i, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Fill to 16, overflow, drain in order, then underflow twice
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, i, i + 1, 0, 0);
    add(0, 1, 0, 0, 999, 16, 1, 0);
    for (int i = 0; i < 16; i++) add(0, 0, 1, 0, 0, 15 - i, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // Minimum depth: full at 4, overflow, push+pop while full
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 200 + i, i + 1, 0, 0);
    add(0, 1, 0, 1, 204, 4, 1, 0);
    add(0, 1, 1, 1, 205, 4, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 3 - i, 1, 0);
    // Switch to minimum depth while holding 6 entries: nothing lost
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 400 + i, i + 1, 1, 0);
    add(0, 0, 0, 1, 0, 6, 1, 0);
    add(0, 1, 0, 1, 406, 6, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 5 - i, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 500 + i, 4 + i, 1, 0);
    // Reset while holding 7 entries
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // Push and pop on empty: push taken, underflow flagged
    add(0, 1, 1, 0, 600, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);

    last_out = '0;
    @(negedge clock);
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) begin
        reset_n = 1'b0; wr_enable = 1'b0; rd_done = 1'b0;
        #1;
        check_zero(k);
        model_q.delete();
        last_out = '0;
        @(negedge clock);
        reset_n = 1'b1;
        continue;
      end
      wr_enable          = vecs[k].wr;
      rd_done            = vecs[k].rd;
      use_min_fifo_depth = vecs[k].um;
      data_in            = mk(vecs[k].d);
      eff     = vecs[k].um ? 4 : 16;
      n       = model_q.size();
      pop_ok  = vecs[k].rd && (n > 0);
      push_ok = vecs[k].wr && ((n < int'(eff)) || pop_ok);
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(mk(vecs[k].d));
      @(negedge clock);
      check("occupancy", k, DW'(occupancy), DW'(vecs[k].occ));
      check("data_available", k, DW'(data_available), DW'(vecs[k].occ >= 1));
      check("data_look_ahead", k, DW'(data_look_ahead), DW'(vecs[k].occ >= 2));
      check("full", k, DW'(full), DW'(vecs[k].occ >= eff));
      check("almost_full", k, DW'(almost_full), DW'(vecs[k].occ >= eff - 2));
      check("overflow_error", k, DW'(overflow_error), DW'(vecs[k].ovf));
      check("underflow_error", k, DW'(underflow_error), DW'(vecs[k].unf));
      if (model_q.size() > 0) begin
        check("data_out", k, data_out, model_q[0]);
        last_out = model_q[0];
      end else begin
        check("data_hold", k, data_out, last_out);
      end
      $display("vec %0d wr=%0d rd=%0d um=%0d occ=%0d dout=%h", k, vecs[k].wr, vecs[k].rd,
               vecs[k].um, occupancy, data_out[31:0]);
    end
    wr_enable = 1'b0;
    rd_done   = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
